sort_result_serializer: RTL and testbench

- Downstream stage of the 8-input bitonic sorter.
- Snapshots the sorter's parallel result (eight elements plus cycle count) on the rising edge of its done flag.
- Streams the elements out one per handshake over a valid/ready byte interface, ascending index order, with a last marker.
- Decouples the sorter's one-shot parallel outputs from narrow consumers (UART/FIFO/bus bridge).

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_rise_detect.sv | 22 ++
 rtl/sort_result_serializer.sv | 147 ++++++++++++++
 tb/tb_sort_result_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants, FSM state type and index-width helper for the bitonic
// sorter result path.
package sort_pkg;

    localparam int SORT_N = 8;
    localparam int SORT_W = 8;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Width of an index into an n-element batch; never narrower than one bit.
    function automatic int sort_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SORT_IDX_W = sort_idx_w(SORT_N);

endpackage

// File: rtl/sort_rise_detect.sv
// Rising-edge detector on a level input. The history register resets high so a
// level already asserted when reset releases is not reported as a new edge.
module sort_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q_reg <= 1'b1;
        end else begin
            level_q_reg <= level;
        end
    end

    assign rise = level & ~level_q_reg;

endmodule

// File: rtl/sort_result_serializer.sv
// Captures the sorter's parallel result on done rising and streams it out one
// element per valid/ready handshake. Define SORT_CHECK_EN to flag unsorted input.
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     done_in,
    input  logic [N*W-1:0]           data_in,
    input  logic [W-1:0]             count_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [sort_idx_w(N)-1:0] out_index,
    output logic                     out_last,
    output logic [W-1:0]             batch_cycles,
    output logic                     busy,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     order_err
);

    localparam int IW = sort_idx_w(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t         state_reg;
    logic [W-1:0]   buf_reg [N];
    logic [W-1:0]   elem [N];
    logic [IW-1:0]  index_reg;
    logic [W-1:0]   out_data_reg;
    logic [W-1:0]   batch_cycles_reg;
    logic           out_valid_reg;
    logic           out_last_reg;
    logic           busy_reg;
    logic           overflow_reg;

    logic rise;
    logic handshake;
    logic final_hs;
    logic capture;
    logic drop;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign elem[gi] = data_in[gi*W +: W];
        end
    endgenerate

    sort_rise_detect u_done_rise (
        .clk   (clk),
        .reset (reset),
        .level (done_in),
        .rise  (rise)
    );

    // A new batch is taken when idle, or in the very cycle the last element
    // leaves, which gives back-to-back batches with no bubble.
    always_comb begin
        handshake = out_valid_reg & out_ready;
        final_hs  = handshake & (index_reg == LAST_IDX);
        capture   = rise & ((state_reg == IDLE) | final_hs);
        drop      = rise & (state_reg == STREAM) & ~final_hs;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            index_reg        <= '0;
            out_data_reg     <= '0;
            batch_cycles_reg <= '0;
            out_valid_reg    <= 1'b0;
            out_last_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            overflow_reg     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            if (capture) begin
                for (int i = 0; i < N; i++) begin
                    buf_reg[i] <= elem[i];
                end
                batch_cycles_reg <= count_in;
                index_reg        <= '0;
                out_data_reg     <= elem[0];
                out_last_reg     <= 1'b0;
                out_valid_reg    <= 1'b1;
                busy_reg         <= 1'b1;
                state_reg        <= STREAM;
            end else if (final_hs) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
                busy_reg      <= 1'b0;
                state_reg     <= IDLE;
            end else if (handshake) begin
                index_reg    <= index_reg + 1'b1;
                out_data_reg <= buf_reg[index_reg + 1'b1];
                out_last_reg <= ((index_reg + 1'b1) == LAST_IDX);
            end

            // Later assignment wins, so a fresh drop beats a simultaneous clear.
            if (clr_overflow) begin
                overflow_reg <= 1'b0;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_index    = index_reg;
    assign out_last     = out_last_reg;
    assign batch_cycles = batch_cycles_reg;
    assign busy         = busy_reg;
    assign overflow     = overflow_reg;

`ifdef SORT_CHECK_EN
    logic [N-2:0] inv;
    logic         order_err_reg;

    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_order
            assign inv[gi] = (elem[gi] > elem[gi+1]);
        end
    endgenerate

    // Sticky until reset; the overflow clear deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            order_err_reg <= 1'b0;
        end else if (capture && (|inv)) begin
            order_err_reg <= 1'b1;
        end
    end

    assign order_err = order_err_reg;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed bench for sort_result_serializer: drain, backpressure, overflow,
// back-to-back capture and reset mid-stream.
module tb_sort_result_serializer;

    localparam int N = 8;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           done_in;
    logic [N*W-1:0] data_in;
    logic [W-1:0]   count_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_index;
    logic           out_last;
    logic [W-1:0]   batch_cycles;
    logic           busy;
    logic           overflow;
    logic           clr_overflow;
    logic           order_err;

    int n_checks = 0;
    int n_errors = 0;

    // Element k sits at bits [k*8 +: 8]; element 0 is the rightmost byte.
    logic [N*W-1:0] batch_a = {8'd10, 8'd9, 8'd8, 8'd6, 8'd4, 8'd3, 8'd2, 8'd1};
    logic [N*W-1:0] batch_r = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    logic [N*W-1:0] batch_f = {8{8'hFF}};
    logic [W-1:0]   exp_a [N] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd9, 8'd10};
    logic [W-1:0]   exp_r [N] = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

`ifdef SORT_CHECK_EN
    localparam logic EXP_ORDER_ERR = 1'b1;
`else
    localparam logic EXP_ORDER_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    sort_result_serializer #(.N(N), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .done_in      (done_in),
        .data_in      (data_in),
        .count_in     (count_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .batch_cycles (batch_cycles),
        .busy         (busy),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .order_err    (order_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int k, input logic [W-1:0] exp_d);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_index"}, 32'(out_index), 32'(k));
        check({tag, "_last"}, 32'(out_last), 32'(k == N - 1));
    endtask

    initial begin
        int hs;
        int k;

        reset = 1'b1; done_in = 1'b0; data_in = '0; count_in = '0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_cycles", 32'(batch_cycles), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_oerr", 32'(order_err), 32'd0);
        reset = 1'b0;
        tick();

        // Normal drain at full rate.
        data_in = batch_a; count_in = 8'd7; out_ready = 1'b1; done_in = 1'b1;
        tick();
        check("drain_cycles", 32'(batch_cycles), 32'd7);
        check("drain_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            check_beat("drain", i, exp_a[i]);
            tick();
        end
        check("drain_end_valid", 32'(out_valid), 32'd0);
        check("drain_end_busy", 32'(busy), 32'd0);

        // Backpressure with ready pattern 1,0,0 repeating.
        done_in = 1'b0; out_ready = 1'b0;
        tick();
        done_in = 1'b1;
        tick();
        hs = 0;
        for (int c = 0; c < 40 && out_valid; c++) begin
            out_ready = (c % 3 == 0);
            check_beat("bp", hs, exp_a[hs < N ? hs : N - 1]);
            if (out_ready) hs++;
            tick();
        end
        check("bp_handshakes", 32'(hs), 32'd8);
        check("bp_end_valid", 32'(out_valid), 32'd0);

        // Overflow: a new rise mid-stream is dropped.
        done_in = 1'b0; out_ready = 1'b1;
        tick();
        done_in = 1'b1; data_in = batch_a; count_in = 8'd7;
        tick();
        done_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("ovf_pre", i, exp_a[i]);
            tick();
        end
        check_beat("ovf_b3", 3, exp_a[3]);
        done_in = 1'b1; data_in = batch_f; count_in = 8'd99;
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_keep_cycles", 32'(batch_cycles), 32'd7);
        check_beat("ovf_b4", 4, exp_a[4]);
        clr_overflow = 1'b1; out_ready = 1'b0;
        tick();
        clr_overflow = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        check_beat("ovf_stall", 4, exp_a[4]);
        out_ready = 1'b1;
        for (int i = 4; i < N; i++) begin
            check_beat("ovf_post", i, exp_a[i]);
            tick();
        end
        check("ovf_end_valid", 32'(out_valid), 32'd0);

        // Back-to-back: new unsorted batch captured on the final handshake.
        done_in = 1'b0;
        tick();
        done_in = 1'b1; data_in = batch_a; count_in = 8'd7;
        tick();
        done_in = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            check_beat("b2b_first", i, exp_a[i]);
            tick();
        end
        check_beat("b2b_lastbeat", N - 1, exp_a[N-1]);
        done_in = 1'b1; data_in = batch_r; count_in = 8'd5;
        tick();
        check("b2b_ovf", 32'(overflow), 32'd0);
        check("b2b_cycles", 32'(batch_cycles), 32'd5);
        check("b2b_oerr", 32'(order_err), 32'(EXP_ORDER_ERR));
        for (int i = 0; i < N; i++) begin
            check_beat("b2b_second", i, exp_r[i]);
            tick();
        end
        check("b2b_end_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream with done_in held high through reset.
        done_in = 1'b0;
        tick();
        done_in = 1'b1; data_in = batch_a; count_in = 8'd7;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_beat("mrst_pre", i, exp_a[i]);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_index", 32'(out_index), 32'd0);
        check("mrst_oerr", 32'(order_err), 32'd0);
        k = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) k++;
        end
        check("mrst_no_capture", 32'(k), 32'd0);
        done_in = 1'b0;
        tick();
        done_in = 1'b1; count_in = 8'd3;
        tick();
        check("mrst_recap_cycles", 32'(batch_cycles), 32'd3);
        check_beat("mrst_recap", 0, exp_a[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
